// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the SISC processor.
// Holds the program counter and instruction register, drives the
// instruction-memory address, decodes the branch condition for the
// control FSM and keeps saturating fetch/branch debug counters.
module fetch_unit #(
  parameter int PC_W  = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_f,
  input  logic [31:0]      read_data,
  input  logic [3:0]       stat,
  input  logic             ir_load,
  input  logic             pc_write,
  input  logic             pc_sel,
  input  logic             br_sel,
  input  logic             pc_rst,
  output logic [PC_W-1:0]  pc_out,
  output logic [31:0]      instr,
  output logic [3:0]       opcode,
  output logic [3:0]       mm,
  output logic [15:0]      imm,
  output logic             br_cond,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] br_cnt
);

  logic [PC_W-1:0]    r_pc;
  logic [31:0]        r_ir;
  logic [CNT_W-1:0]   r_fetch_cnt;
  logic [CNT_W-1:0]   r_br_cnt;

  logic [PC_W-1:0]    w_pc_nxt;
  logic               w_br_taken;
  logic signed [15:0] w_imm_s;
  logic [PC_W-1:0]    w_off;
  logic [PC_W-1:0]    w_abs;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign w_imm_s = signed'(r_ir[15:0]);
  assign w_off   = PC_W'(w_imm_s);      // sign-extended branch offset
  assign w_abs   = PC_W'(r_ir[15:0]);   // zero-extended absolute target

  // Next-PC selection: clear beats increment beats branch; otherwise hold.
  always_comb begin
    w_pc_nxt   = r_pc;
    w_br_taken = 1'b0;
    if (pc_rst) begin
      w_pc_nxt = '0;
    end else if (pc_write) begin
      if (!pc_sel) begin
        w_pc_nxt = r_pc + PC_W'(1);
      end else begin
        w_br_taken = 1'b1;
        w_pc_nxt   = br_sel ? w_abs : (r_pc + w_off);
      end
    end
  end

  // PC register; relative branches use the pre-edge PC as their base.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) r_pc <= '0;
    else        r_pc <= w_pc_nxt;
  end

  // Instruction register captures memory data for the pre-edge PC.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f)       r_ir <= '0;
    else if (ir_load) r_ir <= read_data;
  end

  // Debug counters; only the asynchronous reset clears them.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      r_fetch_cnt <= '0;
      r_br_cnt    <= '0;
    end else begin
      if (ir_load)    r_fetch_cnt <= sat_inc(r_fetch_cnt);
      if (w_br_taken) r_br_cnt    <= sat_inc(r_br_cnt);
    end
  end

  // Branch condition: BRA/BRR test any masked flag, BNE/BNR test none.
  always_comb begin
    br_cond = 1'b0;
    case (r_ir[31:28])
      4'd4, 4'd5: br_cond =  |(stat & r_ir[27:24]);
      4'd6, 4'd7: br_cond = ~|(stat & r_ir[27:24]);
      default:    br_cond = 1'b0;
    endcase
  end

  assign pc_out    = r_pc;
  assign instr     = r_ir;
  assign opcode    = r_ir[31:28];
  assign mm        = r_ir[27:24];
  assign imm       = r_ir[15:0];
  assign fetch_cnt = r_fetch_cnt;
  assign br_cnt    = r_br_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed-vector bench for fetch_unit.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_f;
  logic [31:0] read_data;
  logic [3:0]  stat;
  logic        ir_load, pc_write, pc_sel, br_sel, pc_rst;
  logic [15:0] pc_out;
  logic [31:0] instr;
  logic [3:0]  opcode, mm;
  logic [15:0] imm;
  logic        br_cond;
  logic [15:0] fetch_cnt, br_cnt;

  int n_checks = 0;
  int n_errors = 0;

  fetch_unit #(.PC_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst_f(rst_f), .read_data(read_data), .stat(stat),
    .ir_load(ir_load), .pc_write(pc_write), .pc_sel(pc_sel),
    .br_sel(br_sel), .pc_rst(pc_rst), .pc_out(pc_out), .instr(instr),
    .opcode(opcode), .mm(mm), .imm(imm), .br_cond(br_cond),
    .fetch_cnt(fetch_cnt), .br_cnt(br_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one cycle of strobes, sample 1 ns after the edge, then idle the strobes.
  task automatic step(input logic il, input logic pw, input logic ps,
                      input logic bs, input logic pr, input logic [31:0] rd);
    ir_load = il; pc_write = pw; pc_sel = ps; br_sel = bs; pc_rst = pr;
    read_data = rd;
    @(posedge clk); #1;
    ir_load = 0; pc_write = 0; pc_sel = 0; br_sel = 0; pc_rst = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pc"},   {16'h0, pc_out},    32'h0);
    chk({tag, "_ir"},   instr,              32'h0);
    chk({tag, "_fc"},   {16'h0, fetch_cnt}, 32'h0);
    chk({tag, "_bc"},   {16'h0, br_cnt},    32'h0);
    chk({tag, "_op"},   {28'h0, opcode},    32'h0);
    chk({tag, "_mm"},   {28'h0, mm},        32'h0);
    chk({tag, "_imm"},  {16'h0, imm},       32'h0);
    chk({tag, "_cond"}, {31'h0, br_cond},   32'h0);
  endtask

  initial begin
    rst_f = 0; read_data = 0; stat = 0;
    ir_load = 0; pc_write = 0; pc_sel = 0; br_sel = 0; pc_rst = 0;
    #3;
    chk_all_zero("por");
    #9 rst_f = 1;                       // released mid-cycle

    // Sequential fetch from address 0
    step(1, 1, 0, 0, 0, 32'h8000_0001);
    step(1, 1, 0, 0, 0, 32'h8000_0002);
    step(1, 1, 0, 0, 0, 32'h8000_0003);
    chk("seq_pc", {16'h0, pc_out}, 32'h3);
    chk("seq_ir", instr, 32'h8000_0003);
    chk("seq_fc", {16'h0, fetch_cnt}, 32'd3);

    // Absolute branch
    step(1, 0, 0, 0, 0, 32'h4200_0020);
    stat = 4'b0010; #1;
    chk("bra_op", {28'h0, opcode}, 32'h4);
    chk("bra_mm", {28'h0, mm}, 32'h2);
    chk("bra_imm", {16'h0, imm}, 32'h0020);
    chk("bra_cond1", {31'h0, br_cond}, 32'h1);
    step(0, 1, 1, 1, 0, 32'h0);
    chk("bra_pc", {16'h0, pc_out}, 32'h0020);
    chk("bra_bc", {16'h0, br_cnt}, 32'h1);
    stat = 4'b0000; #1;
    chk("bra_cond0", {31'h0, br_cond}, 32'h0);

    // Relative branch with backward wrap, then increment wrap
    step(0, 0, 0, 0, 1, 32'h0);
    chk("rst_pc", {16'h0, pc_out}, 32'h0);
    chk("rst_bc", {16'h0, br_cnt}, 32'h1);
    step(0, 1, 0, 0, 0, 32'h0);
    step(1, 1, 0, 0, 0, 32'h5100_FFFC);  // load coincident with increment to 2
    chk("simul_ir", instr, 32'h5100_FFFC);
    chk("rel_base", {16'h0, pc_out}, 32'h2);
    step(0, 1, 1, 0, 0, 32'h0);
    chk("rel_pc", {16'h0, pc_out}, 32'hFFFE);
    chk("rel_bc", {16'h0, br_cnt}, 32'h2);
    step(0, 1, 0, 0, 0, 32'h0);
    chk("inc_ffff", {16'h0, pc_out}, 32'hFFFF);
    step(0, 1, 0, 0, 0, 32'h0);
    chk("inc_wrap", {16'h0, pc_out}, 32'h0000);

    // BNE / BNR inversion and non-branch opcode
    step(1, 0, 0, 0, 0, 32'h6100_0010);
    stat = 4'b0001; #1;
    chk("bne_cond0", {31'h0, br_cond}, 32'h0);
    stat = 4'b1000; #1;
    chk("bne_cond1", {31'h0, br_cond}, 32'h1);
    step(1, 0, 0, 0, 0, 32'h7000_0004);
    chk("bnr_mm0", {31'h0, br_cond}, 32'h1);
    step(1, 0, 0, 0, 0, 32'h3F00_0000);
    stat = 4'b1111; #1;
    chk("other_op", {31'h0, br_cond}, 32'h0);
    chk("fc_mid", {16'h0, fetch_cnt}, 32'd8);

    // Priority: pc_rst beats a branch write
    step(0, 1, 0, 0, 0, 32'h0);
    chk("pre_pr_pc", {16'h0, pc_out}, 32'h1);
    step(0, 1, 1, 1, 1, 32'h0);
    chk("pr_pc", {16'h0, pc_out}, 32'h0);
    chk("pr_bc", {16'h0, br_cnt}, 32'h2);

    // Build PC=0x0040, IR=0x1234_5678, then reset asynchronously mid-cycle
    step(1, 0, 0, 0, 0, 32'h4000_0040);
    step(0, 1, 1, 1, 0, 32'h0);
    step(1, 0, 0, 0, 0, 32'h1234_5678);
    chk("pre_ar_pc", {16'h0, pc_out}, 32'h0040);
    chk("pre_ar_ir", instr, 32'h1234_5678);
    chk("pre_ar_bc", {16'h0, br_cnt}, 32'h3);
    #2 rst_f = 0;
    #1;
    chk_all_zero("ar");
    ir_load = 1; pc_write = 1; read_data = 32'hFFFF_FFFF;
    @(posedge clk); @(posedge clk); #1;
    chk_all_zero("ar_hold");
    #3 rst_f = 1;                       // mid-cycle release
    step(1, 1, 0, 0, 0, 32'h8000_0001);
    chk("post_ar_pc", {16'h0, pc_out}, 32'h1);
    chk("post_ar_ir", instr, 32'h8000_0001);
    chk("post_ar_fc", {16'h0, fetch_cnt}, 32'h1);

    // Fetch counter saturation
    ir_load = 1;
    repeat (16'hFFFE - 1) @(posedge clk);
    #1;
    chk("fc_fffe", {16'h0, fetch_cnt}, 32'hFFFE);
    repeat (3) @(posedge clk);
    #1;
    ir_load = 0;
    chk("fc_sat", {16'h0, fetch_cnt}, 32'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the SISC processor: holds the program counter (PC) and the instruction register (IR), and drives the instruction-memory address. It sits directly upstream of the control FSM. It feeds the FSM `opcode`, `mm` and a branch-condition flag, and it acts on the FSM's `ir_load`, `pc_sel`, `br_sel`, `pc_write` and `pc_rst` strobes. It also keeps saturating fetch and branch counters for debug.

## Interface
- `PC_W`, 16: PC / instruction-memory address width.
- `CNT_W`, 16: width of the debug counters.
- `clk` in 1: system clock, posedge active.
- `rst_f` in 1: asynchronous, active-low reset.
- `read_data` in 32: instruction-memory output at address `pc_out`, valid when `ir_load` is sampled.
- `stat` in 4: status register output (C,N,V,Z in bits 3..0).
- `ir_load` in 1: capture `read_data` into IR on this edge.
- `pc_write` in 1: update PC on this edge.
- `pc_sel` in 1: 0 = PC+1, 1 = branch target.
- `br_sel` in 1: 0 = relative target, 1 = absolute target.
- `pc_rst` in 1: synchronous PC clear from the control FSM.
- `pc_out` out PC_W: current PC, drives the instruction-memory address.
- `instr` out 32: IR contents.
- `opcode` out 4: `instr[31:28]`.
- `mm` out 4: `instr[27:24]`.
- `imm` out 16: `instr[15:0]`.
- `br_cond` out 1: branch condition for the instruction held in IR (combinational).
- `fetch_cnt` out CNT_W: number of IR loads, saturating.
- `br_cnt` out CNT_W: number of taken branches (`pc_sel` PC writes), saturating.

## Operation
- **Reset (`rst_f` low, asynchronous):**
  - `pc_out`, `instr`, `fetch_cnt` and `br_cnt` are cleared to 0 immediately, regardless of `clk`.
  - `opcode`, `mm`, `imm` and `br_cond` follow from the cleared IR: 0 for all, and `br_cond` = 0.
  - No register changes while `rst_f` is low.
- **PC update at posedge, priority order:**
  1. `pc_rst` = 1: PC <= 0. `br_cnt` is unchanged.
  2. `pc_write` = 1 and `pc_sel` = 0: PC <= PC + 1, modulo 2^PC_W. 0xFFFF wraps to 0x0000.
  3. `pc_write` = 1, `pc_sel` = 1, `br_sel` = 1: PC <= `imm` (absolute; upper bits zero when PC_W > 16).
  4. `pc_write` = 1, `pc_sel` = 1, `br_sel` = 0: PC <= PC + sign-extended `imm`, modulo 2^PC_W. Wrap in both directions is silent.
  5. Otherwise PC holds.
- **Relative base:** the PC value at the branch edge. The FSM increments PC during fetch, so the offset is measured from the instruction after the branch.
- **IR:** `instr` <= `read_data` on a posedge with `ir_load` = 1, otherwise it holds. `opcode`, `mm` and `imm` are pure slices of IR.
- **Simultaneous `ir_load` and `pc_write`:**
  - IR captures `read_data` for the pre-edge `pc_out`.
  - PC updates on the same edge.
  - There is no bypass of the new PC into IR.
- **`br_cond` (combinational from IR and `stat`):**
  - Opcode 4 (BRA) or 5 (BRR): `br_cond` = |(`stat` & `mm`).
  - Opcode 6 (BNE) or 7 (BNR): `br_cond` = ~|(`stat` & `mm`).
  - All other opcodes: 0.
  - `mm` = 0 gives 0 for BRA/BRR and 1 for BNE/BNR.
- **Counters:**
  - `fetch_cnt` increments on every edge with `ir_load` = 1.
  - `br_cnt` increments on every edge where case 3 or 4 applies.
  - Both stick at all-ones and never wrap.
  - `pc_rst` does not clear them; only `rst_f` does.

## Timing
- The block is a single clock domain. All state changes on posedge `clk`, except asynchronous clear on negedge `rst_f`.
- PC update latency is 1 cycle: the new `pc_out` is visible after the edge at which `pc_write` is sampled.
- Instruction memory is combinational from `pc_out`. Therefore `read_data` for a new PC is usable at the next edge.
- IR latency is 1 cycle. `opcode`, `mm`, `imm` and `br_cond` are valid right after the loading edge, in time for the FSM decode state.
- `br_cond` responds to a `stat` change with no clock; it is combinational.
- Reset released mid-cycle: the first active edge after `rst_f` rises behaves normally, starting from PC = 0.
- Asserting `rst_f` mid-operation aborts any pending update. A branch or load sampled on an edge coincident with the `rst_f` fall is discarded.

## Test plan
- **Async reset:**
  - Stimulus: PC = 0x0040, IR = 0x1234_5678, counters nonzero; drop `rst_f` between edges.
  - Required: all outputs are 0 before the next posedge and remain 0 while `rst_f` is low.
- **Sequential fetch:**
  - Stimulus: from reset, 3 cycles of `ir_load` = 1 and `pc_write` = 1 with `pc_sel` = 0; memory returns 0x8000_0001, 0x8000_0002, 0x8000_0003 at addresses 0, 1, 2.
  - Required: PC = 3, `instr` = 0x8000_0003, `fetch_cnt` = 3.
- **Absolute branch:**
  - Stimulus: IR = 0x4200_0020 (BRA, `mm` = 2), `stat` = 0b0010.
  - Required: `br_cond` = 1.
  - Stimulus: then `pc_write` = 1, `pc_sel` = 1, `br_sel` = 1.
  - Required: PC = 0x0020, `br_cnt` = 1.
  - Stimulus: with `stat` = 0b0000.
  - Required: `br_cond` = 0.
- **Relative branch with wrap:**
  - Stimulus: PC = 0x0002, IR = 0x5100_FFFC (BRR, offset -4), relative branch strobe.
  - Required: PC = 0xFFFE.
  - Stimulus: PC = 0xFFFF, increment.
  - Required: PC = 0x0000.
- **BNE/BNR inversion:**
  - Stimulus: IR = 0x6100_0010 (BNE), `stat` = 0b0001.
  - Required: `br_cond` = 0.
  - Stimulus: `stat` = 0b1000.
  - Required: `br_cond` = 1.
  - Stimulus: IR = 0x7000_0004 (BNR, `mm` = 0).
  - Required: `br_cond` = 1.
- **Priority and saturation:**
  - Stimulus: `pc_rst` = 1 together with `pc_write` = 1, `pc_sel` = 1.
  - Required: PC = 0, `br_cnt` unchanged.
  - Stimulus: `fetch_cnt` preloaded to 0xFFFE by 0xFFFE loads, then 3 more loads.
  - Required: `fetch_cnt` = 0xFFFF.
